// File: rtl/uart_pkg.sv
// UART shared definitions: frame width, default timing constants and
// the receiver FSM state encoding, shared with the future transmitter.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int DEF_OVS     = 16;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: tick_o pulses once every CLK_DIV clocks.
// Ports: clk, rst_n, restart_i (sync restart from 0), tick_o.
module uart_rx_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 with macro UART_RX_PARITY_EN), oversampled.
// Ports: clk, rst_n, rxd in; data/data_valid/data_ready byte handshake;
// frame_err, overrun_err, parity_err one-cycle error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int OVS     = DEF_OVS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int OW = $clog2(OVS);
  localparam logic [OW-1:0] MID  = OW'(OVS / 2 - 1);
  localparam logic [OW-1:0] FULL = OW'(OVS - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic sync1_q, sync2_q, prev_q;
  logic rx_s, fall_d, restart_d, tick;

  rx_state_e            state_q;
  logic [OW-1:0]        os_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 fe_q;
  logic                 ov_q;
  logic                 par_ok_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s      = sync2_q;
  assign fall_d    = prev_q & ~sync2_q;
  assign restart_d = (state_q == ST_IDLE) & fall_d;

  uart_rx_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(restart_d),
    .tick_o   (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic pe_q;
  assign par_ok_d   = ~par_bad_q;
  assign parity_err = pe_q;
`else
  assign par_ok_d   = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q <= 1'b0;
`endif
      if (valid_q && data_ready) valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (fall_d) begin
            state_q <= ST_START;
            os_q    <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (os_q == MID) begin
              os_q    <= '0;
              bit_q   <= '0;
              state_q <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              os_q <= os_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (os_q == FULL) begin
              os_q    <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_q   <= bit_q + 1'b1;
              if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end
            end else begin
              os_q <= os_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick) begin
            if (os_q == FULL) begin
              os_q      <= '0;
              par_bad_q <= rx_s ^ (^shift_q);
              state_q   <= ST_STOP;
            end else begin
              os_q <= os_q + 1'b1;
            end
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_STOP: begin
          if (tick) begin
            if (os_q == FULL) begin
              os_q <= '0;
`ifdef UART_RX_PARITY_EN
              pe_q <= par_bad_q;
`endif
              if (!rx_s) begin
                fe_q    <= 1'b1;
                state_q <= ST_BREAK;
              end else begin
                state_q <= ST_IDLE;
              end
              // Deliver only good frames; an unread byte wins over new.
              if (rx_s && par_ok_d) begin
                if (valid_q && !data_ready) begin
                  ov_q <= 1'b1;
                end else begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end
              end
            end else begin
              os_q <= os_q + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_err   = fe_q;
  assign overrun_err = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with CLK_DIV=1, OVS=16 (16 clocks/bit).
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int hs_cnt = 0;
  int vcyc = 0;
  int cyc = 0;
  int t0 = 0;
  int t_rise = -1;
  int lat_nom;
  logic valid_d = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx #(
    .CLK_DIV(1),
    .OVS    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .parity_err (parity_err)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: counts flag pulses and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (parity_err) pe_cnt++;
      if (data_valid) vcyc++;
      if (data_valid && !valid_d) t_rise = cyc;
      if (data_valid && data_ready) begin
        hs_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got %h expected none", data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            n_err++;
            $display("FAIL byte: got %h expected %h", data, e);
          end
        end
      end
      valid_d = data_valid;
    end else begin
      valid_d = 1'b0;
    end
  end

  task automatic bit_o(input logic v);
    rxd = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stp);
    t0 = cyc;
    bit_o(1'b0);
    for (int i = 0; i < 8; i++) bit_o(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_o(^b);
`endif
    bit_o(stp);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_p(input logic [7:0] b, input logic par);
    bit_o(1'b0);
    for (int i = 0; i < 8; i++) bit_o(b[i]);
    bit_o(par);
    bit_o(1'b1);
  endtask
`endif

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef UART_RX_PARITY_EN
    lat_nom = 170;
`else
    lat_nom = 154;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_fe", int'(frame_err), 0);
    check("rst_ov", int'(overrun_err), 0);
    check("rst_pe", int'(parity_err), 0);
    check("rst_sync", int'(dut.sync1_q & dut.sync2_q), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    // Single byte, consumer always ready
    data_ready = 1'b1;
    t_rise = -1;
    vcyc = 0;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    idle(20);
    check("a5_hs", hs_cnt, 1);
    check("a5_valid_cycles", vcyc, 1);
    check("a5_latency_ok",
          int'((t_rise - t0) >= lat_nom - 1 &&
               (t_rise - t0) <= lat_nom + 1), 1);
    check("a5_flags", fe_cnt + ov_cnt + pe_cnt, 0);

    // Back-to-back bytes, consumer stalled -> overrun
    data_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    idle(10);
    check("ovr_cnt", ov_cnt, 1);
    check("ovr_valid", int'(data_valid), 1);
    check("ovr_data", int'(data), 'h3C);
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_valid_drop", int'(data_valid), 0);
    check("ovr_hs", hs_cnt, 2);

    // Bad stop bit followed by a long break
    send(8'h55, 1'b0);
    idle(40);
    check("brk_fe", fe_cnt, 1);
    check("brk_state", int'(dut.state_q), int'(ST_BREAK));
    check("brk_no_data", hs_cnt, 2);
    rxd = 1'b1;
    idle(5);
    check("brk_exit", int'(dut.state_q), int'(ST_IDLE));
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1);
    idle(20);
    check("brk_12_hs", hs_cnt, 3);
    check("brk_fe_once", fe_cnt, 1);

    // Short glitch on an idle line
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(40);
    check("glitch_hs", hs_cnt, 3);
    check("glitch_flags", fe_cnt + ov_cnt + pe_cnt, 2);
    check("glitch_state", int'(dut.state_q), int'(ST_IDLE));

    // Reset in the middle of a frame
    bit_o(1'b0);
    for (int i = 0; i < 4; i++) bit_o(1'b1);
    idle(8);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(40);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1);
    idle(20);
    check("rst_mid_hs", hs_cnt, 4);
    check("rst_mid_flags", fe_cnt + ov_cnt + pe_cnt, 2);

`ifdef UART_RX_PARITY_EN
    send_p(8'h07, 1'b0);
    idle(20);
    check("par_bad_pe", pe_cnt, 1);
    check("par_bad_hs", hs_cnt, 4);
    exp_q.push_back(8'h07);
    send_p(8'h07, 1'b1);
    idle(20);
    check("par_ok_hs", hs_cnt, 5);
    check("par_ok_pe", pe_cnt, 1);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
